// File: rtl/player_ctrl.sv
// Player rotation stage: synchronises the direction buttons, edge-detects the game FSM
// commands and maintains the current and previous-frame player angle.
module player_ctrl #(
  parameter int ANGLE_W     = 9,
  parameter int ANGLE_STEPS = 360,
  parameter int START_ANGLE = 270,
  parameter int STEP_SLOW   = 4,
  parameter int STEP_FAST   = 8,
  parameter int HOLD_FRAMES = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               update,
  input  logic               game_reset,
  input  logic               revert_player,
  input  logic               game_over,
  output logic [ANGLE_W-1:0] angle_new,
  output logic [ANGLE_W-1:0] angle_old,
  output logic               moving
);

  localparam int AW1    = ANGLE_W + 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [AW1-1:0]     STEPS_X = AW1'(ANGLE_STEPS);
  localparam logic [ANGLE_W-1:0] START_X = ANGLE_W'(START_ANGLE);
  localparam logic [HOLD_W-1:0]  HOLD_X  = HOLD_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_e;

  logic               r_left_meta, r_left_sync, r_right_meta, r_right_sync;
  logic               r_update_d, r_reset_d, r_revert_d;
  logic [ANGLE_W-1:0] r_angle_new, r_angle_old;
  logic               r_moving;
  logic [HOLD_W-1:0]  r_hold;
  dir_e               r_last_dir;

  logic               w_update_rise, w_reset_rise, w_revert_rise;
  dir_e               w_dir;
  logic [AW1-1:0]     w_step, w_cur, w_sum;
  logic [ANGLE_W-1:0] w_right_angle, w_left_angle;
  logic [ANGLE_W-1:0] w_angle_new_nxt, w_angle_old_nxt;
  logic               w_moving_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  dir_e               w_last_dir_nxt;

  assign w_update_rise = update & ~r_update_d;
  assign w_reset_rise  = game_reset & ~r_reset_d;
  assign w_revert_rise = revert_player & ~r_revert_d;

  // Angle arithmetic is one bit wider than the angle so neither wrap can overflow.
  always_comb begin
    w_dir = DIR_NONE;
    if (r_left_sync && !r_right_sync)      w_dir = DIR_LEFT;
    else if (r_right_sync && !r_left_sync) w_dir = DIR_RIGHT;

    w_step        = (r_hold >= HOLD_X) ? AW1'(STEP_FAST) : AW1'(STEP_SLOW);
    w_cur         = {1'b0, r_angle_new};
    w_sum         = w_cur + w_step;
    w_right_angle = (w_sum >= STEPS_X) ? ANGLE_W'(w_sum - STEPS_X) : ANGLE_W'(w_sum);
    w_left_angle  = (w_cur < w_step) ? ANGLE_W'(w_cur + STEPS_X - w_step)
                                     : ANGLE_W'(w_cur - w_step);
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    w_angle_new_nxt = r_angle_new;
    w_angle_old_nxt = r_angle_old;
    w_moving_nxt    = r_moving;
    w_hold_nxt      = r_hold;
    w_last_dir_nxt  = r_last_dir;

    if (w_reset_rise) begin
      w_angle_new_nxt = START_X;
      w_angle_old_nxt = START_X;
      w_moving_nxt    = 1'b0;
      w_hold_nxt      = '0;
      w_last_dir_nxt  = DIR_NONE;
    end else if (w_revert_rise) begin
      w_angle_new_nxt = r_angle_old;
      w_moving_nxt    = 1'b0;
      w_hold_nxt      = '0;
    end else if (w_update_rise && !game_over) begin
      w_angle_old_nxt = r_angle_new;
      if (w_dir == DIR_NONE) begin
        w_moving_nxt   = 1'b0;
        w_hold_nxt     = '0;
        w_last_dir_nxt = DIR_NONE;
      end else begin
        w_angle_new_nxt = (w_dir == DIR_RIGHT) ? w_right_angle : w_left_angle;
        w_moving_nxt    = 1'b1;
        if (w_dir == r_last_dir) begin
          w_hold_nxt = (r_hold >= HOLD_X) ? r_hold : r_hold + 1'b1;
        end else begin
          w_hold_nxt     = HOLD_W'(1);
          w_last_dir_nxt = w_dir;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_left_meta  <= 1'b0;
      r_left_sync  <= 1'b0;
      r_right_meta <= 1'b0;
      r_right_sync <= 1'b0;
      r_update_d   <= 1'b0;
      r_reset_d    <= 1'b0;
      r_revert_d   <= 1'b0;
      r_angle_new  <= START_X;
      r_angle_old  <= START_X;
      r_moving     <= 1'b0;
      r_hold       <= '0;
      r_last_dir   <= DIR_NONE;
    end else begin
      r_left_meta  <= btn_left;
      r_left_sync  <= r_left_meta;
      r_right_meta <= btn_right;
      r_right_sync <= r_right_meta;
      r_update_d   <= update;
      r_reset_d    <= game_reset;
      r_revert_d   <= revert_player;
      r_angle_new  <= w_angle_new_nxt;
      r_angle_old  <= w_angle_old_nxt;
      r_moving     <= w_moving_nxt;
      r_hold       <= w_hold_nxt;
      r_last_dir   <= w_last_dir_nxt;
    end
  end

  assign angle_new = r_angle_new;
  assign angle_old = r_angle_old;
  assign moving    = r_moving;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: a reference model pushes expected outputs per clock
// into a scoreboard queue, and directed checks pin the key angles from the rotation rules.
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       update = 1'b0, game_reset = 1'b0, revert_player = 1'b0, game_over = 1'b0;
  logic [8:0] angle_new, angle_old;
  logic       moving;

  player_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .update       (update),
    .game_reset   (game_reset),
    .revert_player(revert_player),
    .game_over    (game_over),
    .angle_new    (angle_new),
    .angle_old    (angle_old),
    .moving       (moving)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] a_new;
    logic [8:0] a_old;
    logic       mv;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state (dir: 0 none, 1 left, 2 right)
  int   m_new = 270, m_old = 270, m_hold = 0, m_last = 0;
  logic m_mv = 1'b0;
  logic m_ls1 = 1'b0, m_ls2 = 1'b0, m_rs1 = 1'b0, m_rs2 = 1'b0;
  logic m_upd_d = 1'b0, m_rst_d = 1'b0, m_rev_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int dir, s;
    if (!rst_n) begin
      m_new = 270; m_old = 270; m_mv = 1'b0; m_hold = 0; m_last = 0;
      m_ls1 = 1'b0; m_ls2 = 1'b0; m_rs1 = 1'b0; m_rs2 = 1'b0;
      m_upd_d = 1'b0; m_rst_d = 1'b0; m_rev_d = 1'b0;
      return;
    end
    dir = (m_ls2 && !m_rs2) ? 1 : ((m_rs2 && !m_ls2) ? 2 : 0);
    if (game_reset && !m_rst_d) begin
      m_new = 270; m_old = 270; m_mv = 1'b0; m_hold = 0; m_last = 0;
    end else if (revert_player && !m_rev_d) begin
      m_new = m_old; m_mv = 1'b0; m_hold = 0;
    end else if (update && !m_upd_d && !game_over) begin
      m_old = m_new;
      if (dir == 0) begin
        m_mv = 1'b0; m_hold = 0; m_last = 0;
      end else begin
        s = (m_hold >= 15) ? 8 : 4;
        m_new = (dir == 2) ? (m_new + s) % 360 : (m_new - s + 360) % 360;
        m_mv = 1'b1;
        if (dir == m_last) m_hold = (m_hold < 15) ? m_hold + 1 : 15;
        else begin
          m_hold = 1; m_last = dir;
        end
      end
    end
    m_ls2 = m_ls1; m_ls1 = btn_left;
    m_rs2 = m_rs1; m_rs1 = btn_right;
    m_upd_d = update; m_rst_d = game_reset; m_rev_d = revert_player;
  endtask

  // One clock: model predicts this edge, DUT result is sampled at the following negedge.
  task automatic step();
    exp_t e;
    model_edge();
    e.a_new = m_new[8:0];
    e.a_old = m_old[8:0];
    e.mv    = m_mv;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("sb_angle_new", 32'(angle_new), 32'(e.a_new));
    check("sb_angle_old", 32'(angle_old), 32'(e.a_old));
    check("sb_moving", 32'(moving), 32'(e.mv));
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_update();
    update = 1'b1; step();
    update = 1'b0; step();
  endtask

  task automatic expect_state(input string tag, input int a_new, input int a_old, input int mv);
    check({tag, "_new"}, 32'(angle_new), a_new);
    check({tag, "_old"}, 32'(angle_old), a_old);
    check({tag, "_mv"}, 32'(moving), mv);
  endtask

  initial begin
    // Reset and idle update
    tick(2);
    expect_state("reset", 270, 270, 0);
    rst_n = 1'b1;
    tick(3);
    pulse_update();
    expect_state("idle_update", 270, 270, 0);

    // Right rotation, slow steps
    btn_right = 1'b1; tick(2);
    pulse_update(); expect_state("right1", 274, 270, 1);
    pulse_update(); expect_state("right2", 278, 274, 1);
    pulse_update(); expect_state("right3", 282, 278, 1);

    // Wrap checks: reach 358, fast right wrap, left wrap, slow right wrap
    btn_right = 1'b0; tick(2); pulse_update();
    btn_right = 1'b1; tick(2);
    for (int i = 0; i < 20 && m_new != 358; i++) pulse_update();
    check("reach_358", 32'(angle_new), 358);
    pulse_update(); expect_state("wrap_right_fast", 6, 358, 1);
    btn_right = 1'b0; tick(2); pulse_update();
    btn_left = 1'b1; tick(2);
    pulse_update(); expect_state("left_to_2", 2, 6, 1);
    pulse_update(); expect_state("wrap_left", 358, 2, 1);
    btn_left = 1'b0; tick(2); pulse_update();
    btn_right = 1'b1; tick(2);
    pulse_update(); expect_state("wrap_right_slow", 2, 358, 1);

    // Game reset, then 20 left updates with the hold threshold
    btn_right = 1'b0;
    game_reset = 1'b1; step();
    game_reset = 1'b0; step();
    expect_state("game_reset1", 270, 270, 0);
    btn_left = 1'b1; tick(2);
    for (int i = 0; i < 20; i++) begin
      pulse_update();
      check("hold_left", 32'(angle_new), (i < 15) ? 270 - 4 * (i + 1) : 210 - 8 * (i - 14));
    end
    btn_left = 1'b0; tick(2);
    pulse_update(); expect_state("release", 170, 170, 0);
    btn_left = 1'b1; tick(2);
    pulse_update(); expect_state("slow_again", 166, 170, 1);

    // Level update held for 10 cycles acts once
    update = 1'b1; tick(10);
    expect_state("level_update", 162, 166, 1);
    update = 1'b0; tick(1);

    // Revert, then revert and update rising together
    revert_player = 1'b1; step();
    revert_player = 1'b0; step();
    expect_state("revert", 166, 166, 0);
    revert_player = 1'b1; update = 1'b1; step();
    revert_player = 1'b0; update = 1'b0; step();
    expect_state("revert_wins", 166, 166, 0);

    // Game over freezes motion; held level does not retrigger when it falls
    btn_left = 1'b0; btn_right = 1'b1; tick(2);
    game_over = 1'b1;
    pulse_update(); expect_state("game_over", 166, 166, 0);
    update = 1'b1; tick(2);
    game_over = 1'b0; tick(2);
    expect_state("no_retrigger", 166, 166, 0);
    update = 1'b0; tick(1);

    game_reset = 1'b1; step();
    game_reset = 1'b0; step();
    expect_state("game_reset2", 270, 270, 0);

    // Both buttons pressed: no motion
    btn_left = 1'b1; tick(2);
    pulse_update(); expect_state("both_buttons", 270, 270, 0);

    // Reset overrides a coincident update edge
    btn_right = 1'b0; tick(2);
    pulse_update(); expect_state("pre_rst", 266, 270, 1);
    rst_n = 1'b0; update = 1'b1; step();
    rst_n = 1'b1; update = 1'b0; step();
    expect_state("rst_mid", 270, 270, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Player rotation stage that sits directly downstream of the game state machine.
- Consumes its update, reset, revert_player and game_over outputs, plus the left/right buttons.
- Maintains the player's current angle (angle_new) and previous-frame angle (angle_old).
- The collision stage tests both angles against the walls, and those results become collided_new/collided_old for the game state machine.

Parameters:
- ANGLE_W, 9: width of angle registers.
- ANGLE_STEPS, 360: angle modulus; legal angles are 0..ANGLE_STEPS-1.
- START_ANGLE, 270: angle loaded on reset and on game restart.
- STEP_SLOW, 4: rotation per update before the hold threshold is reached.
- STEP_FAST, 8: rotation per update once the hold threshold is reached. Constraint: STEP_SLOW <= STEP_FAST < ANGLE_STEPS.
- HOLD_FRAMES, 15: number of consecutive same-direction moving updates before the fast step applies.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous reset, active-low.
- btn_left, in, 1: left button; asynchronous, active-high.
- btn_right, in, 1: right button; asynchronous, active-high.
- update, in, 1: frame update request from the game FSM; level, may stay high for more than one cycle.
- game_reset, in, 1: the game FSM's reset output; level.
- revert_player, in, 1: restore the previous angle; level.
- game_over, in, 1: game-over flag; freezes motion while high.
- angle_new, out, ANGLE_W: current player angle.
- angle_old, out, ANGLE_W: angle before the last committed update.
- moving, out, 1: high if the last committed update changed the angle.

Behaviour:
- One clock domain (clk). rst_n is synchronous and active-low.
- Reset values (rst_n=0 at a clock edge):
  - angle_new = angle_old = START_ANGLE.
  - moving = 0.
  - hold counter = 0, last direction = none.
  - Synchronizer and edge-detect registers = 0.
- Button input path:
  - Each button passes through a 2-flop synchronizer, so a button is seen 2 cycles after it changes.
  - dir = LEFT if sync_left and not sync_right.
  - dir = RIGHT if sync_right and not sync_left.
  - Otherwise dir = NONE (both or neither pressed).
- Command edge detect:
  - update, game_reset and revert_player are each registered once.
  - Each acts only on its rising edge (input high, registered copy low), so a multi-cycle level acts exactly once.
  - Response is registered: outputs change on the clock edge after the cycle in which the rising edge is seen.
- Priority when rising edges coincide in the same cycle: game_reset > revert_player > update. Lower-priority edges in that cycle are dropped, not deferred.
- game_reset edge:
  - angle_new = angle_old = START_ANGLE.
  - moving = 0, hold counter = 0, last direction = none.
- revert_player edge:
  - angle_new = angle_old; angle_old unchanged.
  - moving = 0, hold counter = 0.
- update edge with game_over = 0:
  - angle_old = angle_new.
  - Step size s = STEP_FAST if hold counter >= HOLD_FRAMES, else STEP_SLOW.
  - RIGHT: angle_new = angle_new + s; if the result >= ANGLE_STEPS, subtract ANGLE_STEPS.
  - LEFT: if angle_new < s, angle_new = angle_new + ANGLE_STEPS - s; otherwise angle_new - s.
  - Use ANGLE_W+1 bit intermediates; no overflow permitted.
  - NONE: angle_new unchanged, moving = 0, hold counter = 0, last direction = none.
  - dir equal to last direction: hold counter increments, saturating at HOLD_FRAMES.
  - dir different from last direction: hold counter = 1, last direction = dir.
  - moving = 1 when dir != NONE.
- update edge with game_over = 1:
  - Ignored: no register changes.
  - Its edge-detect register still updates, so a level held across game_over falling does not retrigger.
- Between edges, all outputs hold their values.
- Invariant: angle_new and angle_old are always in 0..ANGLE_STEPS-1.
- Reset mid-operation: rst_n overrides everything in the same cycle, including pending edges.

Test Plan:
- Reset, then release with no buttons pressed, and pulse update -> angle_new=270, angle_old=270, moving=0.
- Hold btn_right, issue 3 single-cycle update pulses -> angle_new 274, 278, 282; angle_old trails by one update; moving=1.
- Hold btn_right from angle 356 and pulse update -> angle_new=0, angle_old=356. Then hold btn_left and pulse update from 2 -> angle_new=358.
- Hold btn_left for 20 updates starting from 270:
  - Updates 1-15 step by 4 (270 -> 210).
  - Updates 16-20 step by 8 (210 -> 170).
  - Release the button and pulse update -> hold counter clears and the next left press steps by 4.
- Hold update high for 10 cycles -> exactly one step. Then assert revert_player -> angle_new=angle_old and moving=0. Assert revert and update rising in the same cycle -> revert wins and no step is taken.
- Assert game_over=1 and pulse update with btn_right held -> angles unchanged. Then pulse game_reset -> both angles = 270. Then press both buttons and pulse update -> no motion.
